// File: rtl/cu_seq_if.sv
// cu_seq_if: control-unit sequencer bus (step/handshake inputs, control and status outputs)
interface cu_seq_if #(parameter int N = 4);
  logic run, halt_req, mem_ready;
  logic [N-1:0] step;
  logic cnt_load, cnt_inc, cnt_clr;
  logic mem_rd, ar_from_pc, ar_from_dr, pc_inc, pc_from_dr, dr_load, ir_load, ac_add, ac_and, ac_inc;
  logic busy, timeout_err, illegal_err;
  logic [15:0] instr_count;
  modport master (
    output run, halt_req, step, mem_ready,
    input  cnt_load, cnt_inc, cnt_clr, mem_rd, ar_from_pc, ar_from_dr, pc_inc, pc_from_dr,
           dr_load, ir_load, ac_add, ac_and, ac_inc, busy, timeout_err, illegal_err, instr_count
  );
  modport slave (
    input  run, halt_req, step, mem_ready,
    output cnt_load, cnt_inc, cnt_clr, mem_rd, ar_from_pc, ar_from_dr, pc_inc, pc_from_dr,
           dr_load, ir_load, ac_add, ac_and, ac_inc, busy, timeout_err, illegal_err, instr_count
  );
endinterface

// File: rtl/cu_sequencer.sv
// cu_sequencer: microprogram step decoder with memory-wait timeout, halt and error handling; CU_SEQ_PERF_EN enables the instruction counter
module cu_sequencer #(
  parameter int N = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input logic clk,
  input logic rst,
  cu_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, INIT, RUN, ERR} state_t;
  state_t state;
  logic [N-1:0] step_v;
  logic [31:0] s;
  logic [7:0] wait_cnt;
  logic halt_pend, illegal_err;
  logic in_run, mem_step, rdy, waiting, illegal, timeout, clr, end_halt;
  assign step_v = bus.step;
  assign s = 32'(step_v);
  assign rdy = bus.mem_ready;
  assign in_run = state == RUN;
  assign mem_step = in_run && (s == 1 || s == 3 || s == 5);
  assign waiting = mem_step && !rdy;
  assign illegal = in_run && s >= 9;
  assign timeout = waiting && wait_cnt == 8'(MEM_TIMEOUT - 1);
  assign clr = state == INIT || (in_run && (s == 4 || s == 6 || s == 7 || s == 8)) || illegal;
  assign end_halt = in_run && clr && halt_pend;
  assign bus.cnt_clr = clr;
  assign bus.cnt_inc = (in_run && s == 0) || (mem_step && rdy);
  assign bus.cnt_load = in_run && s == 2;
  assign bus.mem_rd = mem_step;
  assign bus.ar_from_pc = in_run && s == 0;
  assign bus.ar_from_dr = in_run && s == 2;
  assign bus.ir_load = in_run && s == 2;
  assign bus.pc_inc = in_run && s == 1 && rdy;
  assign bus.dr_load = mem_step && rdy;
  assign bus.ac_add = in_run && s == 4;
  assign bus.ac_and = in_run && s == 6;
  assign bus.pc_from_dr = in_run && s == 7;
  assign bus.ac_inc = in_run && s == 8;
  assign bus.busy = state == INIT || in_run;
  assign bus.timeout_err = state == ERR;
  assign bus.illegal_err = illegal_err;
  // control FSM, memory wait counter, pending halt and sticky illegal-step flag
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      wait_cnt <= '0;
      halt_pend <= 1'b0;
      illegal_err <= 1'b0;
    end else begin
      state <= state == IDLE ? (bus.run ? INIT : IDLE) :
               state == INIT ? RUN :
               state == ERR ? ERR :
               timeout ? ERR : end_halt ? IDLE : RUN;
      wait_cnt <= waiting ? wait_cnt + 8'd1 : '0;
      halt_pend <= bus.halt_req || (halt_pend && !end_halt);
      illegal_err <= illegal_err || illegal;
    end
`ifdef CU_SEQ_PERF_EN
  logic [15:0] instr_count;
  // counts instructions as they pass FETCH3, wrapping at 16 bits
  always_ff @(posedge clk or posedge rst)
    if (rst) instr_count <= '0;
    else if (in_run && s == 2) instr_count <= instr_count + 16'd1;
  assign bus.instr_count = instr_count;
`else
  assign bus.instr_count = '0;
`endif
endmodule

// File: tb/tb_cu_sequencer.sv
// tb_cu_sequencer: directed vectors, corner sequences and randomized model comparison for cu_sequencer
module tb_cu_sequencer;
  localparam int MT = 15;
`ifdef CU_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam logic [15:0] CL = 16'h8000, CI = 16'h4000, CC = 16'h2000, MR = 16'h1000,
                          AP = 16'h0800, AD = 16'h0400, PI = 16'h0200, PD = 16'h0100,
                          DL = 16'h0080, IL = 16'h0040, AA = 16'h0020, AN = 16'h0010,
                          AI = 16'h0008, BZ = 16'h0004, TO = 16'h0002, IE = 16'h0001;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  cu_seq_if #(.N(4)) b();
  cu_sequencer #(.N(4), .MEM_TIMEOUT(MT)) dut (.clk(clk), .rst(rst), .bus(b));
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] step;
    logic rdy;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[13];
  logic [15:0] ref_op[16];
  int ms, mw;
  bit mh, mi;
  logic [15:0] mc;

  function automatic logic [15:0] act();
    return {b.cnt_load, b.cnt_inc, b.cnt_clr, b.mem_rd, b.ar_from_pc, b.ar_from_dr, b.pc_inc,
            b.pc_from_dr, b.dr_load, b.ir_load, b.ac_add, b.ac_and, b.ac_inc, b.busy,
            b.timeout_err, b.illegal_err};
  endfunction

  task automatic chk(input string nm, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic tick(input logic r, input logic h, input logic [3:0] s, input logic mr,
                      input logic [15:0] e, input string nm);
    b.run = r; b.halt_req = h; b.step = s; b.mem_ready = mr;
    #1 chk(nm, act(), e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1 chk("rst_hold_ctl", act(), 16'h0);
    chk("rst_hold_cnt", b.instr_count, 16'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ms = 0; mw = 0; mh = 0; mi = 0; mc = '0;
  endtask

  task automatic start();
    tick(1, 0, 0, 1, 16'h0, "idle_run");
    tick(0, 0, 0, 1, CC | BZ, "init");
  endtask

  function automatic bit is_mem(logic [3:0] s);
    return s == 1 || s == 3 || s == 5;
  endfunction

  function automatic logic [15:0] model_out(logic [3:0] s, logic r);
    logic [15:0] o;
    o = mi ? IE : 16'h0;
    if (ms == 1) o |= CC | BZ;
    else if (ms == 2) o |= BZ | ((is_mem(s) && !r) ? MR : ref_op[s]);
    else if (ms == 3) o |= TO;
    return o;
  endfunction

  task automatic model_step(logic r, logic h, logic [3:0] s, logic mr);
    bit fin;
    fin = ms == 2 && model_out(s, mr)[13] && mh;
    if (ms == 2 && s >= 9) mi = 1;
    if (ms == 2 && s == 2) mc = mc + (PERF ? 16'd1 : 16'd0);
    mw = (ms == 2 && is_mem(s) && !mr) ? mw + 1 : 0;
    if (ms == 0) ms = r ? 1 : 0;
    else if (ms == 1) ms = 2;
    else if (ms == 2) ms = mw == MT ? 3 : fin ? 0 : 2;
    mh = h || (mh && !fin);
  endtask

  initial begin
    tbl[0]  = '{4'd0,  1'b1, AP | CI | BZ};
    tbl[1]  = '{4'd1,  1'b1, MR | DL | PI | CI | BZ};
    tbl[2]  = '{4'd1,  1'b0, MR | BZ};
    tbl[3]  = '{4'd2,  1'b1, IL | AD | CL | BZ};
    tbl[4]  = '{4'd3,  1'b1, MR | DL | CI | BZ};
    tbl[5]  = '{4'd3,  1'b0, MR | BZ};
    tbl[6]  = '{4'd4,  1'b1, AA | CC | BZ};
    tbl[7]  = '{4'd5,  1'b0, MR | BZ};
    tbl[8]  = '{4'd5,  1'b1, MR | DL | CI | BZ};
    tbl[9]  = '{4'd6,  1'b1, AN | CC | BZ};
    tbl[10] = '{4'd7,  1'b0, PD | CC | BZ};
    tbl[11] = '{4'd8,  1'b1, AI | CC | BZ};
    tbl[12] = '{4'd15, 1'b1, CC | BZ};
    for (int i = 0; i < 16; i++) ref_op[i] = CC;
    ref_op[0] = AP | CI;
    ref_op[1] = MR | DL | PI | CI;
    ref_op[2] = IL | AD | CL;
    ref_op[3] = MR | DL | CI;
    ref_op[4] = AA | CC;
    ref_op[5] = MR | DL | CI;
    ref_op[6] = AN | CC;
    ref_op[7] = PD | CC;
    ref_op[8] = AI | CC;
    b.run = 0; b.halt_req = 0; b.step = 0; b.mem_ready = 0;
    @(negedge clk);
    do_reset();
    // basic ADD instruction with memory always ready
    start();
    tick(0, 0, 0, 1, AP | CI | BZ, "add_fetch1");
    tick(0, 0, 1, 1, MR | DL | PI | CI | BZ, "add_fetch2");
    tick(0, 0, 2, 1, IL | AD | CL | BZ, "add_fetch3");
    tick(0, 0, 3, 1, MR | DL | CI | BZ, "add1");
    tick(0, 0, 4, 1, AA | CC | BZ, "add2");
    do_reset();
    // short memory wait, then decode table, then illegal step stickiness
    start();
    tick(0, 0, 0, 1, AP | CI | BZ, "wait_fetch1");
    for (int i = 0; i < 3; i++) tick(0, 0, 1, 0, MR | BZ, "wait_hold");
    tick(0, 0, 1, 1, MR | DL | PI | CI | BZ, "wait_done");
    tick(0, 0, 2, 1, IL | AD | CL | BZ, "wait_no_err");
    for (int i = 0; i < 13; i++) tick(0, 0, tbl[i].step, tbl[i].rdy, tbl[i].exp, $sformatf("tbl%0d", i));
    tick(0, 0, 0, 1, AP | CI | BZ | IE, "illegal_sticky");
    tick(0, 0, 3, 1, MR | DL | CI | BZ | IE, "illegal_still");
    do_reset();
    tick(0, 0, 0, 1, 16'h0, "illegal_cleared");
    // memory timeout into ERR
    start();
    for (int i = 0; i < MT; i++) tick(0, 0, 3, 0, MR | BZ, "to_wait");
    tick(0, 0, 3, 0, TO, "timeout_err");
    tick(0, 0, 0, 1, TO, "err_hold");
    tick(1, 0, 0, 1, TO, "err_ignores_run");
    do_reset();
    tick(0, 0, 0, 1, 16'h0, "err_cleared");
    // ready on the last tolerated cycle wins
    start();
    for (int i = 0; i < MT - 1; i++) tick(0, 0, 3, 0, MR | BZ, "rw_wait");
    tick(0, 0, 3, 1, MR | DL | CI | BZ, "ready_wins");
    tick(0, 0, 4, 1, AA | CC | BZ, "no_timeout");
    // halt request mid-AND completes the instruction then idles
    tick(0, 0, 0, 1, AP | CI | BZ, "h_fetch1");
    tick(0, 1, 5, 1, MR | DL | CI | BZ, "h_and1");
    tick(0, 0, 6, 1, AN | CC | BZ, "h_and2");
    tick(0, 0, 0, 1, 16'h0, "halted_idle");
    // run and halt together: one instruction then idle
    do_reset();
    tick(1, 1, 0, 1, 16'h0, "rh_idle");
    tick(0, 0, 0, 1, CC | BZ, "rh_init");
    tick(0, 0, 0, 1, AP | CI | BZ, "rh_fetch1");
    tick(0, 0, 1, 1, MR | DL | PI | CI | BZ, "rh_fetch2");
    tick(0, 0, 2, 1, IL | AD | CL | BZ, "rh_fetch3");
    tick(0, 0, 8, 1, AI | CC | BZ, "rh_inc1");
    tick(0, 0, 0, 1, 16'h0, "rh_halted");
    #1 chk("instr_count_one", b.instr_count, PERF ? 16'd1 : 16'd0);
    @(negedge clk);
    // reset in the middle of a memory wait
    start();
    tick(0, 0, 0, 1, AP | CI | BZ, "rw_fetch1");
    tick(0, 0, 1, 0, MR | BZ, "rw_pending");
    do_reset();
    tick(0, 0, 1, 1, 16'h0, "no_dr_after_rst");
    // randomized run against the reference model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 2) do_reset();
      else begin
        logic r, h, mr;
        logic [3:0] s;
        logic [15:0] e;
        r = $urandom_range(0, 3) == 0;
        h = $urandom_range(0, 15) == 0;
        s = $urandom_range(0, 7) == 0 ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
        mr = $urandom_range(0, 3) != 0;
        e = model_out(s, mr);
        b.run = r; b.halt_req = h; b.step = s; b.mem_ready = mr;
        #1 chk("rand_ctl", act(), e);
        chk("rand_cnt", b.instr_count, mc);
        chk("rand_cnt_onehot", 16'($countones({b.cnt_load, b.cnt_inc, b.cnt_clr}) <= 1), 16'd1);
        @(posedge clk);
        model_step(r, h, s, mr);
        @(negedge clk);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
